decode_issue_ctrl: RTL

//  Scoreboard-based issue controller between fetch and execute. Holds one decoded

---
 rtl/decode_issue_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/decode_issue_ctrl.sv
// Issue controller between fetch and execute.
// Holds one decoded instruction and issues it only when its source and
// destination registers are free of pending writes. A busy-bit scoreboard
// tracks in-flight writes. Writebacks and flushes clear busy bits. A
// saturating counter records the cycles in which a hazard held off an
// otherwise acceptable instruction.
module decode_issue_ctrl #(
  parameter int ARCH_BITS = 32,
  parameter int NUM_REGS  = 32,
  parameter bit REG0_ZERO = 1'b1,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ARCH_BITS-1:0] in_inst,
  input  logic                 in_rd_s1,
  input  logic                 in_rd_s2,
  input  logic                 in_wr_dst,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ARCH_BITS-1:0] out_inst,
  output logic [6:0]           out_opcode,
  output logic [4:0]           out_dst,
  output logic [4:0]           out_src1,
  output logic [4:0]           out_src2,
  output logic [9:0]           out_imm,
  input  logic                 out_ready,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_dst,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy,
  output logic [CNT_BITS-1:0]  stall_cnt
);

  logic                 out_valid_q, out_valid_d;
  logic [ARCH_BITS-1:0] inst_q, inst_d;
  logic                 wr_q, wr_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  logic [NUM_REGS-1:0]  busy_eff;
  logic [4:0]           in_dst, in_src1, in_src2;
  logic                 hazard, slot_free, accept, flush_clr, stall_evt;

  assign in_dst  = in_inst[24:20];
  assign in_src1 = in_inst[19:15];
  assign in_src2 = in_inst[14:10];

  // Hazard check against the registered scoreboard; r0 is masked when hardwired.
  always_comb begin
    busy_eff = busy_q;
    if (REG0_ZERO) busy_eff[0] = 1'b0;
    hazard = (in_rd_s1  & busy_eff[in_src1]) |
             (in_rd_s2  & busy_eff[in_src2]) |
             (in_wr_dst & busy_eff[in_dst]);
  end

  assign slot_free = ~out_valid_q | out_ready;
  assign in_ready  = slot_free & ~hazard & ~flush;
  assign accept    = in_valid & in_ready;
  // A held inst that issues in the flush cycle is already gone; only squash an unconsumed one.
  assign flush_clr = flush & out_valid_q & ~out_ready & wr_q;
  assign stall_evt = in_valid & slot_free & hazard & ~flush;

  // Scoreboard update: clears first so a same-cycle set from an accept wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_dst] = 1'b0;
    if (flush_clr) busy_d[inst_q[24:20]] = 1'b0;
    if (accept && in_wr_dst) busy_d[in_dst] = 1'b1;
    if (REG0_ZERO) busy_d[0] = 1'b0;
  end

  // Issue register: load on accept, drop on consume or flush, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    wr_d        = wr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      inst_d      = in_inst;
      wr_d        = in_wr_dst;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating hazard-stall counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_evt && (cnt_q != {CNT_BITS{1'b1}})) cnt_d = cnt_q + CNT_BITS'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      wr_q        <= 1'b0;
      busy_q      <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_inst   = inst_q;
  assign out_opcode = inst_q[31:25];
  assign out_dst    = inst_q[24:20];
  assign out_src1   = inst_q[19:15];
  assign out_src2   = inst_q[14:10];
  assign out_imm    = inst_q[9:0];
  assign busy       = busy_q;
  assign stall_cnt  = cnt_q;

endmodule
